// File: rtl/pwm_meter_pkg.sv
// Shared field codes, channel state encoding and STATUS byte layout for the pulse-width meter.
// Optional min/max tracking is enabled by defining PWM_MINMAX_EN.
package pwm_meter_pkg;

`ifdef PWM_MINMAX_EN
    localparam int FIELD_W = 3;
`else
    localparam int FIELD_W = 2;
`endif

    localparam logic [FIELD_W-1:0] FIELD_HIGH   = FIELD_W'(0);
    localparam logic [FIELD_W-1:0] FIELD_LOW    = FIELD_W'(1);
    localparam logic [FIELD_W-1:0] FIELD_PERIOD = FIELD_W'(2);
    localparam logic [FIELD_W-1:0] FIELD_STATUS = FIELD_W'(3);
`ifdef PWM_MINMAX_EN
    localparam logic [FIELD_W-1:0] FIELD_MIN    = 3'd4;
    localparam logic [FIELD_W-1:0] FIELD_MAX    = 3'd5;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } ch_state_t;

    localparam int STAT_FRESH_BIT = 0;
    localparam int STAT_OVF_BIT   = 1;
    localparam int STAT_IDLE_BIT  = 2;

    function automatic logic [7:0] status_byte(input logic idle, input logic ovf, input logic fresh);
        logic [7:0] b;
        b                 = 8'h00;
        b[STAT_IDLE_BIT]  = idle;
        b[STAT_OVF_BIT]   = ovf;
        b[STAT_FRESH_BIT] = fresh;
        return b;
    endfunction

endpackage

// File: rtl/pulse_width_meter_multi_channel.sv
// One measurement channel: synchroniser, IDLE/HIGH/LOW FSM, saturating counters, live and shadow results.
// PWM_MINMAX_EN adds per-channel period min/max tracking.
module pulse_width_channel
    import pwm_meter_pkg::*;
#(
    parameter int COUNTER_BITS = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    freq_in,
    input  logic                    snap,
    output logic [COUNTER_BITS-1:0] sh_high,
    output logic [COUNTER_BITS-1:0] sh_low,
    output logic [COUNTER_BITS-1:0] sh_period,
`ifdef PWM_MINMAX_EN
    output logic [COUNTER_BITS-1:0] sh_min,
    output logic [COUNTER_BITS-1:0] sh_max,
`endif
    output logic                    sh_fresh,
    output logic                    sh_ovf,
    output logic                    live_ovf,
    output logic                    idle
);

    localparam logic [COUNTER_BITS-1:0] CNT_MAX  = {COUNTER_BITS{1'b1}};
    localparam logic [COUNTER_BITS-1:0] CNT_ZERO = {COUNTER_BITS{1'b0}};
    localparam logic [COUNTER_BITS-1:0] CNT_ONE  = {{(COUNTER_BITS-1){1'b0}}, 1'b1};

    function automatic logic [COUNTER_BITS-1:0] sat_inc(input logic [COUNTER_BITS-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                    prev_q, prev_d;
    ch_state_t               state_q, state_d;
    logic [COUNTER_BITS-1:0] cnt_hi_q, cnt_hi_d, cnt_lo_q, cnt_lo_d, hi_hold_q, hi_hold_d;
    logic [COUNTER_BITS-1:0] live_high_q, live_high_d, live_low_q, live_low_d;
    logic [COUNTER_BITS-1:0] live_period_q, live_period_d;
    logic [COUNTER_BITS-1:0] sh_high_q, sh_high_d, sh_low_q, sh_low_d, sh_period_q, sh_period_d;
    logic                    fresh_q, fresh_d, ovf_q, ovf_d, sh_fresh_q, sh_fresh_d, sh_ovf_q, sh_ovf_d;
`ifdef PWM_MINMAX_EN
    logic [COUNTER_BITS-1:0] min_q, min_d, max_q, max_d, sh_min_q, sh_min_d, sh_max_q, sh_max_d;
    logic [COUNTER_BITS-1:0] min_base_s, max_base_s;
`endif

    logic                    s_s, rise_s, fall_s, complete_s, ovf_evt_s;
    logic [COUNTER_BITS:0]   sum_s;
    logic [COUNTER_BITS-1:0] period_new_s, inc_hi_s, inc_lo_s;

    // Edge detection, measurement FSM, sticky flags and snapshot capture.
    always_comb begin
        s_s          = sync_q[SYNC_STAGES-1];
        rise_s       = s_s & ~prev_q;
        fall_s       = ~s_s & prev_q;
        sync_d       = {sync_q[SYNC_STAGES-2:0], freq_in};
        prev_d       = s_s;
        sum_s        = {1'b0, hi_hold_q} + {1'b0, cnt_lo_q};
        period_new_s = sum_s[COUNTER_BITS] ? CNT_MAX : sum_s[COUNTER_BITS-1:0];
        inc_hi_s     = sat_inc(cnt_hi_q);
        inc_lo_s     = sat_inc(cnt_lo_q);

        state_d       = state_q;
        cnt_hi_d      = cnt_hi_q;
        cnt_lo_d      = cnt_lo_q;
        hi_hold_d     = hi_hold_q;
        live_high_d   = live_high_q;
        live_low_d    = live_low_q;
        live_period_d = live_period_q;
        complete_s    = 1'b0;
        ovf_evt_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    cnt_hi_d = CNT_ONE;
                    state_d  = ST_HIGH;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (fall_s) begin
                    hi_hold_d = cnt_hi_q;
                    cnt_lo_d  = CNT_ONE;
                    state_d   = ST_LOW;
                end else begin
                    cnt_hi_d  = inc_hi_s;
                    ovf_evt_s = (inc_hi_s == CNT_MAX);
                end
            end
            ST_LOW: begin
                if (rise_s) begin
                    complete_s    = 1'b1;
                    live_high_d   = hi_hold_q;
                    live_low_d    = cnt_lo_q;
                    live_period_d = period_new_s;
                    ovf_evt_s     = sum_s[COUNTER_BITS];
                    cnt_hi_d      = CNT_ONE;
                    state_d       = ST_HIGH;
                end else begin
                    cnt_lo_d  = inc_lo_s;
                    ovf_evt_s = (inc_lo_s == CNT_MAX);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A completion or overflow coinciding with a snapshot wins over the clear.
        fresh_d = complete_s ? 1'b1 : (snap ? 1'b0 : fresh_q);
        ovf_d   = ovf_evt_s  ? 1'b1 : (snap ? 1'b0 : ovf_q);

        if (snap) begin
            sh_high_d   = live_high_q;
            sh_low_d    = live_low_q;
            sh_period_d = live_period_q;
            sh_fresh_d  = fresh_q;
            sh_ovf_d    = ovf_q;
        end else begin
            sh_high_d   = sh_high_q;
            sh_low_d    = sh_low_q;
            sh_period_d = sh_period_q;
            sh_fresh_d  = sh_fresh_q;
            sh_ovf_d    = sh_ovf_q;
        end

`ifdef PWM_MINMAX_EN
        min_base_s = snap ? CNT_MAX  : min_q;
        max_base_s = snap ? CNT_ZERO : max_q;
        if (complete_s) begin
            min_d = (period_new_s < min_base_s) ? period_new_s : min_base_s;
            max_d = (period_new_s > max_base_s) ? period_new_s : max_base_s;
        end else begin
            min_d = min_base_s;
            max_d = max_base_s;
        end
        sh_min_d = snap ? min_q : sh_min_q;
        sh_max_d = snap ? max_q : sh_max_q;
`endif
    end

    // Channel state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q        <= {SYNC_STAGES{1'b0}};
            prev_q        <= 1'b0;
            state_q       <= ST_IDLE;
            cnt_hi_q      <= CNT_ZERO;
            cnt_lo_q      <= CNT_ZERO;
            hi_hold_q     <= CNT_ZERO;
            live_high_q   <= CNT_ZERO;
            live_low_q    <= CNT_ZERO;
            live_period_q <= CNT_ZERO;
            sh_high_q     <= CNT_ZERO;
            sh_low_q      <= CNT_ZERO;
            sh_period_q   <= CNT_ZERO;
            fresh_q       <= 1'b0;
            ovf_q         <= 1'b0;
            sh_fresh_q    <= 1'b0;
            sh_ovf_q      <= 1'b0;
`ifdef PWM_MINMAX_EN
            min_q         <= CNT_MAX;
            max_q         <= CNT_ZERO;
            sh_min_q      <= CNT_ZERO;
            sh_max_q      <= CNT_ZERO;
`endif
        end else begin
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            state_q       <= state_d;
            cnt_hi_q      <= cnt_hi_d;
            cnt_lo_q      <= cnt_lo_d;
            hi_hold_q     <= hi_hold_d;
            live_high_q   <= live_high_d;
            live_low_q    <= live_low_d;
            live_period_q <= live_period_d;
            sh_high_q     <= sh_high_d;
            sh_low_q      <= sh_low_d;
            sh_period_q   <= sh_period_d;
            fresh_q       <= fresh_d;
            ovf_q         <= ovf_d;
            sh_fresh_q    <= sh_fresh_d;
            sh_ovf_q      <= sh_ovf_d;
`ifdef PWM_MINMAX_EN
            min_q         <= min_d;
            max_q         <= max_d;
            sh_min_q      <= sh_min_d;
            sh_max_q      <= sh_max_d;
`endif
        end
    end

    assign sh_high   = sh_high_q;
    assign sh_low    = sh_low_q;
    assign sh_period = sh_period_q;
    assign sh_fresh  = sh_fresh_q;
    assign sh_ovf    = sh_ovf_q;
    assign live_ovf  = ovf_q;
    assign idle      = (state_q == ST_IDLE);
`ifdef PWM_MINMAX_EN
    assign sh_min    = sh_min_q;
    assign sh_max    = sh_max_q;
`endif

endmodule

// File: rtl/pulse_width_meter_multi.sv
// Multi-channel pulse-width meter: NUM_CH channels, coherent snapshot control and byte-wide readout.
// Define PWM_MINMAX_EN to add the MIN/MAX period fields.
module pulse_width_meter_multi
    import pwm_meter_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int COUNTER_BITS = 16,
    parameter int SYNC_STAGES  = 2,
    localparam int NB          = COUNTER_BITS / 8,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BYTE_W      = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_CH-1:0]  FREQ_IN,
    input  logic               SNAP_REQ,
    output logic               SNAP_ACK,
    input  logic [CH_W-1:0]    CH_SEL,
    input  logic [FIELD_W-1:0] FIELD_SEL,
    input  logic [BYTE_W-1:0]  BYTE_SEL,
    output logic [7:0]         DATA_OUT,
    output logic               ANY_OVF
);

    logic [COUNTER_BITS-1:0] sh_high_s   [NUM_CH];
    logic [COUNTER_BITS-1:0] sh_low_s    [NUM_CH];
    logic [COUNTER_BITS-1:0] sh_period_s [NUM_CH];
`ifdef PWM_MINMAX_EN
    logic [COUNTER_BITS-1:0] sh_min_s    [NUM_CH];
    logic [COUNTER_BITS-1:0] sh_max_s    [NUM_CH];
`endif
    logic [NUM_CH-1:0]       sh_fresh_s, sh_ovf_s, live_ovf_s, idle_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pulse_width_channel #(
            .COUNTER_BITS (COUNTER_BITS),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_ch (
            .clk       (CLK),
            .rst_n     (RST_N),
            .freq_in   (FREQ_IN[g]),
            .snap      (SNAP_REQ),
            .sh_high   (sh_high_s[g]),
            .sh_low    (sh_low_s[g]),
            .sh_period (sh_period_s[g]),
`ifdef PWM_MINMAX_EN
            .sh_min    (sh_min_s[g]),
            .sh_max    (sh_max_s[g]),
`endif
            .sh_fresh  (sh_fresh_s[g]),
            .sh_ovf    (sh_ovf_s[g]),
            .live_ovf  (live_ovf_s[g]),
            .idle      (idle_s[g])
        );
    end

    logic [COUNTER_BITS-1:0] word_s;
    logic [7:0]              stat_s;
    logic [7:0]              data_d, data_q;
    logic                    snap_ack_d, snap_ack_q, any_ovf_d, any_ovf_q;

    // Readout mux; an unmatched channel or byte select leaves the byte at zero.
    always_comb begin
        word_s = {COUNTER_BITS{1'b0}};
        stat_s = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (CH_SEL == CH_W'(i)) begin
                stat_s = status_byte(idle_s[i], sh_ovf_s[i], sh_fresh_s[i]);
                case (FIELD_SEL)
                    FIELD_HIGH:   word_s = sh_high_s[i];
                    FIELD_LOW:    word_s = sh_low_s[i];
                    FIELD_PERIOD: word_s = sh_period_s[i];
`ifdef PWM_MINMAX_EN
                    FIELD_MIN:    word_s = sh_min_s[i];
                    FIELD_MAX:    word_s = sh_max_s[i];
`endif
                    default:      word_s = {COUNTER_BITS{1'b0}};
                endcase
            end else begin
                stat_s = stat_s;
            end
        end

        data_d = 8'h00;
        if (FIELD_SEL == FIELD_STATUS) begin
            data_d = (BYTE_SEL == {BYTE_W{1'b0}}) ? stat_s : 8'h00;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (BYTE_SEL == BYTE_W'(b)) begin
                    data_d = word_s[b*8 +: 8];
                end else begin
                    data_d = data_d;
                end
            end
        end

        snap_ack_d = SNAP_REQ;
        any_ovf_d  = |live_ovf_s;
    end

    // Registered readout, acknowledge and overflow summary.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            data_q     <= 8'h00;
            snap_ack_q <= 1'b0;
            any_ovf_q  <= 1'b0;
        end else begin
            data_q     <= data_d;
            snap_ack_q <= snap_ack_d;
            any_ovf_q  <= any_ovf_d;
        end
    end

    assign DATA_OUT = data_q;
    assign SNAP_ACK = snap_ack_q;
    assign ANY_OVF  = any_ovf_q;

endmodule

// File: tb/tb_pulse_width_meter_multi.sv
// Directed bench: instance A (4 ch, 16 bit) for function and readout, instance B (3 ch, 8 bit) for saturation and select limits.
module tb_pulse_width_meter_multi;
    import pwm_meter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [3:0]         a_freq;
    logic               a_snap, a_ack, a_ovf;
    logic [1:0]         a_ch;
    logic [FIELD_W-1:0] a_field;
    logic [0:0]         a_byte;
    logic [7:0]         a_data;
    logic [2:0]         b_freq;
    logic               b_snap, b_ack, b_ovf;
    logic [1:0]         b_ch;
    logic [FIELD_W-1:0] b_field;
    logic [0:0]         b_byte;
    logic [7:0]         b_data;
    logic [7:0]         v;

    int checks   = 0;
    int failures = 0;

    pulse_width_meter_multi #(.NUM_CH(4), .COUNTER_BITS(16), .SYNC_STAGES(2)) dut_a (
        .CLK(clk), .RST_N(rst_n), .FREQ_IN(a_freq), .SNAP_REQ(a_snap), .SNAP_ACK(a_ack),
        .CH_SEL(a_ch), .FIELD_SEL(a_field), .BYTE_SEL(a_byte), .DATA_OUT(a_data), .ANY_OVF(a_ovf)
    );

    pulse_width_meter_multi #(.NUM_CH(3), .COUNTER_BITS(8), .SYNC_STAGES(2)) dut_b (
        .CLK(clk), .RST_N(rst_n), .FREQ_IN(b_freq), .SNAP_REQ(b_snap), .SNAP_ACK(b_ack),
        .CH_SEL(b_ch), .FIELD_SEL(b_field), .BYTE_SEL(b_byte), .DATA_OUT(b_data), .ANY_OVF(b_ovf)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_a(input logic [1:0] ch, input logic [FIELD_W-1:0] f, input logic b, output logic [7:0] r);
        a_ch = ch; a_field = f; a_byte = b;
        tick(1);
        r = a_data;
    endtask

    task automatic rd_b(input logic [1:0] ch, input logic [FIELD_W-1:0] f, input logic b, output logic [7:0] r);
        b_ch = ch; b_field = f; b_byte = b;
        tick(1);
        r = b_data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; a_freq = 4'h0; b_freq = 3'h0;
        tick(2);
        rst_n = 1'b1;
    endtask

    function automatic logic lvl(input int t, input int h, input int l);
        if (h == 0) return 1'b0;
        return ((t % (h + l)) < h);
    endfunction

    task automatic run_a(input int n, input int h0, input int l0, input int h1, input int l1,
                         input int h2, input int l2, input int h3, input int l3);
        for (int t = 0; t < n; t++) begin
            a_freq = {lvl(t, h3, l3), lvl(t, h2, l2), lvl(t, h1, l1), lvl(t, h0, l0)};
            tick(1);
        end
    endtask

    task automatic snap_a();
        a_snap = 1'b1; tick(1); a_snap = 1'b0;
    endtask

    task automatic snap_b();
        b_snap = 1'b1; tick(1); b_snap = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; a_freq = 4'h0; b_freq = 3'h0; a_snap = 1'b0; b_snap = 1'b0;
        a_ch = 2'd0; a_field = FIELD_HIGH; a_byte = 1'b0;
        b_ch = 2'd0; b_field = FIELD_HIGH; b_byte = 1'b0;

        // Reset with inputs toggling
        for (int i = 0; i < 2; i++) begin
            a_freq = ~a_freq; b_freq = ~b_freq;
            tick(1);
        end
        chk("rst_data_a", a_data, 8'h00);
        chk("rst_ack_a", {7'd0, a_ack}, 8'h00);
        chk("rst_ovf_a", {7'd0, a_ovf}, 8'h00);
        chk("rst_data_b", b_data, 8'h00);
        rst_n = 1'b1; a_freq = 4'h0; b_freq = 3'h0;
        rd_a(2'd0, FIELD_STATUS, 1'b0, v); chk("rst_status", v, 8'h04);

        // Square wave 5/3 on ch0
        run_a(30, 5, 3, 0, 1, 0, 1, 0, 1);
        snap_a();
        chk("sq_ack", {7'd0, a_ack}, 8'h01);
        rd_a(2'd0, FIELD_HIGH, 1'b0, v);   chk("sq_high", v, 8'h05);
        chk("sq_ack_drop", {7'd0, a_ack}, 8'h00);
        rd_a(2'd0, FIELD_LOW, 1'b0, v);    chk("sq_low", v, 8'h03);
        rd_a(2'd0, FIELD_PERIOD, 1'b0, v); chk("sq_period", v, 8'h08);
        rd_a(2'd0, FIELD_PERIOD, 1'b1, v); chk("sq_period_b1", v, 8'h00);
        rd_a(2'd0, FIELD_STATUS, 1'b0, v); chk("sq_status", v, 8'h01);
        rd_a(2'd0, FIELD_STATUS, 1'b1, v); chk("status_byte1", v, 8'h00);

        // Four channels concurrently
        do_reset();
        run_a(560, 2, 2, 10, 6, 100, 156, 1, 1);
        snap_a();
        rd_a(2'd0, FIELD_PERIOD, 1'b0, v); chk("mc_p0", v, 8'h04);
        rd_a(2'd1, FIELD_PERIOD, 1'b0, v); chk("mc_p1", v, 8'h10);
        rd_a(2'd1, FIELD_HIGH, 1'b0, v);   chk("mc_h1", v, 8'h0A);
        rd_a(2'd2, FIELD_PERIOD, 1'b0, v); chk("mc_p2_b0", v, 8'h00);
        rd_a(2'd2, FIELD_PERIOD, 1'b1, v); chk("mc_p2_b1", v, 8'h01);
        rd_a(2'd2, FIELD_HIGH, 1'b0, v);   chk("mc_h2", v, 8'h64);
        rd_a(2'd2, FIELD_LOW, 1'b0, v);    chk("mc_l2", v, 8'h9C);
        rd_a(2'd3, FIELD_PERIOD, 1'b0, v); chk("mc_p3", v, 8'h02);
        chk("mc_no_ovf", {7'd0, a_ovf}, 8'h00);

        // Saturation on 8-bit instance, ch1
        do_reset();
        b_freq[1] = 1'b1; tick(300);
        b_freq[1] = 1'b0; tick(4);
        b_freq[1] = 1'b1; tick(4);
        chk("sat_anyovf", {7'd0, b_ovf}, 8'h01);
        snap_b();
        rd_b(2'd1, FIELD_HIGH, 1'b0, v);   chk("sat_high", v, 8'hFF);
        rd_b(2'd1, FIELD_LOW, 1'b0, v);    chk("sat_low", v, 8'h04);
        rd_b(2'd1, FIELD_PERIOD, 1'b0, v); chk("sat_period", v, 8'hFF);
        rd_b(2'd1, FIELD_STATUS, 1'b0, v); chk("sat_status", v, 8'h03);
        for (int t = 0; t < 24; t++) begin
            b_freq[1] = lvl(t, 3, 3);
            tick(1);
        end
        snap_b();
        rd_b(2'd1, FIELD_STATUS, 1'b0, v); chk("clean_status", v, 8'h01);
        rd_b(2'd1, FIELD_HIGH, 1'b0, v);   chk("clean_high", v, 8'h03);
        chk("clean_anyovf", {7'd0, b_ovf}, 8'h00);

        // Select edge cases
        rd_b(2'd3, FIELD_HIGH, 1'b0, v);   chk("ch_oob", v, 8'h00);
        rd_b(2'd1, FIELD_HIGH, 1'b1, v);   chk("byte_oob", v, 8'h00);
        rd_b(2'd1, FIELD_HIGH, 1'b0, v);   chk("sel_latency", v, 8'h03);
        rd_b(2'd0, FIELD_STATUS, 1'b0, v); chk("idle_ch_status", v, 8'h04);

        // Completion coinciding with snapshot
        do_reset();
        a_freq[0] = 1'b1; tick(4);
        a_freq[0] = 1'b0; tick(3);
        a_freq[0] = 1'b1; tick(2);
        snap_a();
        rd_a(2'd0, FIELD_STATUS, 1'b0, v); chk("simul_fresh0", v, 8'h00);
        rd_a(2'd0, FIELD_HIGH, 1'b0, v);   chk("simul_high0", v, 8'h00);
        snap_a();
        rd_a(2'd0, FIELD_STATUS, 1'b0, v); chk("simul_fresh1", v, 8'h01);
        rd_a(2'd0, FIELD_HIGH, 1'b0, v);   chk("simul_high", v, 8'h04);
        rd_a(2'd0, FIELD_LOW, 1'b0, v);    chk("simul_low", v, 8'h03);
        rd_a(2'd0, FIELD_PERIOD, 1'b0, v); chk("simul_period", v, 8'h07);

`ifdef PWM_MINMAX_EN
        // Period min/max over 6, 10, 8
        do_reset();
        a_freq[0] = 1'b1; tick(3); a_freq[0] = 1'b0; tick(3);
        a_freq[0] = 1'b1; tick(5); a_freq[0] = 1'b0; tick(5);
        a_freq[0] = 1'b1; tick(4); a_freq[0] = 1'b0; tick(4);
        a_freq[0] = 1'b1; tick(4);
        snap_a();
        rd_a(2'd0, FIELD_MIN, 1'b0, v);    chk("min", v, 8'h06);
        rd_a(2'd0, FIELD_MAX, 1'b0, v);    chk("max", v, 8'h0A);
        rd_a(2'd0, FIELD_PERIOD, 1'b0, v); chk("mm_period", v, 8'h08);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
